// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle add / subtract / compare unit.
// Operands are processed CHUNK bits per cycle, LSB chunk first, so a
// result takes NCH = WIDTH/CHUNK cycles after acceptance. SUB, CMPS and
// CMPU all compute a + ~b + 1; ADD computes a + b + cin.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (ready only while idle)
//   a, b, cin, op         operands, carry-in (ADD only), operation
//                         (00 ADD, 01 SUB, 10 CMPS, 11 CMPU)
//   out_valid / out_ready result handshake
//   sum                   a+b+cin (ADD) or a-b (others), mod 2^WIDTH
//   cout, ovf             carry out of MSB (1 = no borrow), signed overflow
//   zero, neg             sum == 0, sum MSB
//   lt, eq                compare results (0 for ADD/SUB)
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic             lt,
    output logic             eq
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_r, b_r;
    logic [1:0]       op_r;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] ca, cb, cs;
    logic             cc;
    logic [WIDTH-1:0] sum_full;
    logic             ovf_n, zero_n, neg_n, lt_n, eq_n;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // next state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // one chunk of the ripple add plus flags of the would-be complete sum
    always_comb begin
        ca       = a_r[cnt*CHUNK +: CHUNK];
        cb       = b_r[cnt*CHUNK +: CHUNK];
        {cc, cs} = {1'b0, ca} + {1'b0, cb} + (CHUNK+1)'(carry);
        sum_full = sum;
        sum_full[cnt*CHUNK +: CHUNK] = cs;
        // carry into the top bit of the chunk recovered from its sum bit;
        // only meaningful on the last chunk, where that bit is the MSB
        ovf_n  = (cs[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1]) ^ cc;
        neg_n  = sum_full[WIDTH-1];
        zero_n = (sum_full == '0);
        case (op_r)
            2'b10:   lt_n = neg_n ^ ovf_n;
            2'b11:   lt_n = ~cc;
            default: lt_n = 1'b0;
        endcase
        eq_n = op_r[1] & zero_n;
    end

    // datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            op_r  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
            neg   <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= (op == 2'b00) ? b : ~b;
                        op_r  <= op;
                        carry <= (op == 2'b00) ? cin : 1'b1;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum   <= sum_full;
                    carry <= cc;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cout <= cc;
                        ovf  <= ovf_n;
                        zero <= zero_n;
                        neg  <= neg_n;
                        lt   <= lt_n;
                        eq   <= eq_n;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
